mem_copy_dma: RTL and testbench

Single-port memory copy engine that acts as the initiator on the 32-bit req/we/be/addr/wdata/rvalid/rdata RAM interface used by the shared dual-port RAM. It connects to one port of that RAM and copies a block of words from a source address to a destination address. Data moves in bursts: the engine reads up to `FifoDepth` words into an internal FIFO, then writes them back out. It sits beside the core as a simple bulk-move helper.

---
 rtl/mem_copy_dma.sv | 210 +++++++++++++++++++++
 tb/tb_mem_copy_dma.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bulk word-copy engine driving one port of a single-cycle RAM.
// Reads up to FifoDepth words from the source pointer into a small FIFO,
// then writes them back out at the destination pointer, until len is done.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  start request (sampled in IDLE only)
//   src_addr_i, dst_addr_i   byte addresses, must be word aligned
//   len_i                    transfer length in 32-bit words
//   busy_o, done_o, err_o    status: transfer active, completion pulse, misaligned start
//   mem_req_o .. mem_wdata_o RAM request side (one access per cycle)
//   mem_rvalid_i, mem_rdata_i RAM response, one cycle after each request
`timescale 1ns / 1ps

module mem_copy_dma #(
  parameter int unsigned FifoDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned LenW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_e;

  state_e            state_q;
  logic [31:0]       src_ptr_q;
  logic [31:0]       dst_ptr_q;
  logic [LenW-1:0]   rem_q;
  logic [CntW-1:0]   burst_q;
  logic [CntW-1:0]   rd_cnt_q;
  logic [CntW-1:0]   wr_cnt_q;
  logic              rd_pend_q;

  logic [31:0]       fifo_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW:0]     cnt_q;

  logic              bypass;
  logic              push;
  logic              pop;
  logic [31:0]       head;
  logic [LenW-1:0]   rem_after;
  logic [CntW-1:0]   burst_after;
  logic              misaligned;

  // Words for the next burst: min(FifoDepth, remaining).
  function automatic logic [CntW-1:0] burst_of(input logic [LenW-1:0] rem);
    if (32'(rem) >= FifoDepth) return CntW'(FifoDepth);
    return CntW'(rem);
  endfunction

  // FIFO control and next-burst arithmetic.
  // A one-word burst leaves the FIFO empty in WAIT, so its only word is taken
  // straight from the RAM response instead of going through the FIFO.
  // rd_pend_q marks that the response in this cycle belongs to a read, so
  // write acknowledgements never reach the FIFO.
  always_comb begin
    bypass      = (state_q == S_WAIT) && (cnt_q == '0);
    head        = bypass ? mem_rdata_i : fifo_q[rd_ptr_q];
    push        = rd_pend_q && mem_rvalid_i && !bypass &&
                  ((state_q == S_READ) || (state_q == S_WAIT));
    pop         = ((state_q == S_WAIT) && !bypass) ||
                  ((state_q == S_WRITE) && (wr_cnt_q != '0));
    rem_after   = rem_q - LenW'(burst_q);
    burst_after = burst_of(rem_after);
    misaligned  = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
  end

  // Burst FIFO storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata_i;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Control FSM; outputs are registered and describe the cycle being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      rem_q       <= '0;
      burst_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      rd_pend_q   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= 4'h0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      rd_pend_q <= mem_req_o && !mem_we_o;
      done_o    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dst_ptr_q <= dst_addr_i;
            rem_q     <= len_i;
            err_o     <= misaligned;
            if (misaligned || (len_i == '0)) begin
              src_ptr_q <= src_addr_i;
              state_q   <= S_FIN;
              done_o    <= 1'b1;
            end else begin
              state_q    <= S_READ;
              busy_o     <= 1'b1;
              burst_q    <= burst_of(len_i);
              rd_cnt_q   <= burst_of(len_i) - CntW'(1);
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_be_o   <= 4'h0;
              mem_addr_o <= src_addr_i;
              src_ptr_q  <= src_addr_i + 32'd4;
            end
          end
        end
        S_READ: begin
          if (rd_cnt_q == '0) begin
            state_q   <= S_WAIT;
            mem_req_o <= 1'b0;
          end else begin
            mem_addr_o <= src_ptr_q;
            src_ptr_q  <= src_ptr_q + 32'd4;
            rd_cnt_q   <= rd_cnt_q - CntW'(1);
          end
        end
        S_WAIT: begin
          state_q     <= S_WRITE;
          mem_req_o   <= 1'b1;
          mem_we_o    <= 1'b1;
          mem_be_o    <= 4'hF;
          mem_addr_o  <= dst_ptr_q;
          dst_ptr_q   <= dst_ptr_q + 32'd4;
          mem_wdata_o <= head;
          wr_cnt_q    <= burst_q - CntW'(1);
        end
        S_WRITE: begin
          if (wr_cnt_q == '0) begin
            rem_q    <= rem_after;
            mem_we_o <= 1'b0;
            mem_be_o <= 4'h0;
            if (rem_after != '0) begin
              state_q    <= S_READ;
              burst_q    <= burst_after;
              rd_cnt_q   <= burst_after - CntW'(1);
              mem_req_o  <= 1'b1;
              mem_addr_o <= src_ptr_q;
              src_ptr_q  <= src_ptr_q + 32'd4;
            end else begin
              state_q   <= S_FIN;
              mem_req_o <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
            end
          end else begin
            mem_addr_o  <= dst_ptr_q;
            dst_ptr_q   <= dst_ptr_q + 32'd4;
            mem_wdata_o <= head;
            wr_cnt_q    <= wr_cnt_q - CntW'(1);
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench for mem_copy_dma: single-cycle RAM model, expected-transaction
// scoreboard filled by the driver and drained by a negedge monitor.
`timescale 1ns / 1ps

module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata  = 32'h0;

  always #5 clk = ~clk;

  mem_copy_dma #(.FifoDepth(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (ram_rvalid),
    .mem_rdata_i  (ram_rdata)
  );

  // RAM model; the only writer of ram (preload goes through pl_*)
  logic [31:0] ram [logic [31:0]];
  logic        pl_en   = 1'b0;
  logic [31:0] pl_addr = 32'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    ram_rvalid <= mem_req_o;
    ram_rdata  <= 32'h0;
    if (pl_en) ram[pl_addr] = pl_data;
    if (mem_req_o && mem_we_o) ram[mem_addr_o] = mem_wdata_o;
    else if (mem_req_o) ram_rdata <= ram.exists(mem_addr_o) ? ram[mem_addr_o] : 32'hBAD0_BAD0;
  end

  typedef struct {
    int          rel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   t0       = 0;
  int   done_rel = 0;
  bit   prev_err = 1'b0;
  bit   new_err  = 1'b0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   mrel;
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @rel_cycle %0d: got %h expected %h", nm, cyc - t0, act, exp);
    end
  endtask

  // Monitor: status every cycle, memory requests against the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mrel = cyc - t0;
      chk("busy_o", 32'(busy_o), 32'(mrel >= 1 && mrel < done_rel));
      chk("done_o", 32'(done_o), 32'(mrel == done_rel));
      chk("err_o", 32'(err_o), 32'((mrel >= 1) ? new_err : prev_err));
      if (mem_req_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req @rel_cycle %0d: got addr %h we %0d expected no request",
                   mrel, mem_addr_o, mem_we_o);
        end else begin
          me = exp_q.pop_front();
          chk("req_cycle", 32'(mrel), 32'(me.rel));
          chk("req_we", 32'(mem_we_o), 32'(me.we));
          chk("req_addr", mem_addr_o, me.addr);
          chk("req_be", 32'(mem_be_o), 32'(me.be));
          if (me.we) chk("req_wdata", mem_wdata_o, me.data);
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      pl_addr = a + 32'(i * 4);
      pl_data = base + 32'(i);
      pl_en   = 1'b1;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;
  endtask

  // Issue one copy; expected schedule: per burst N reads, 1 idle, N writes
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input logic [31:0] base,
                          input int glitch);
    exp_t        e;
    int          rel;
    int          rem;
    int          n;
    int          k;
    bit          mis;
    logic [31:0] a;
    logic [31:0] got;
    mis = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
    rel = 1;
    rem = mis ? 0 : int'(len);
    k   = 0;
    while (rem > 0) begin
      n = (rem > 4) ? 4 : rem;
      for (int i = 0; i < n; i++) begin
        e.rel = rel + i; e.we = 1'b0; e.addr = src + 32'((k + i) * 4);
        e.data = 32'h0; e.be = 4'h0;
        exp_q.push_back(e);
      end
      rel += n + 1;
      for (int i = 0; i < n; i++) begin
        e.rel = rel + i; e.we = 1'b1; e.addr = dst + 32'((k + i) * 4);
        e.data = base + 32'(k + i); e.be = 4'hF;
        exp_q.push_back(e);
      end
      rel += n;
      k   += n;
      rem -= n;
    end
    @(posedge clk);
    #1;
    prev_err   = new_err;
    new_err    = mis;
    t0         = cyc;
    done_rel   = rel;
    start_i    = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
    for (int c = 1; c <= rel + 1; c++) begin
      @(posedge clk);
      #1;
      start_i = (c == glitch);
      if (c == glitch) begin
        src_addr_i = 32'h0000_0F00;
        dst_addr_i = 32'h0000_0E00;
        len_i      = 16'd2;
      end
    end
    start_i = 1'b0;
    chk("pending_reqs", 32'(exp_q.size()), 32'd0);
    if (!mis) begin
      for (int i = 0; i < int'(len); i++) begin
        a   = dst + 32'(i * 4);
        got = ram.exists(a) ? ram[a] : 32'hDEAD_DEAD;
        chk("dst_word", got, base + 32'(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    src_addr_i = 32'h0;
    dst_addr_i = 32'h0;
    len_i      = 16'h0;
    #12;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    #10;
    rst_n = 1'b1;

    preload(32'h10, 1, 32'hDEAD_BEEF);
    run_copy(32'h10, 32'h40, 16'd1, 32'hDEAD_BEEF, 0);

    preload(32'h0, 8, 32'd1);
    run_copy(32'h0, 32'h100, 16'd8, 32'd1, 6);           // start pulse during WRITE

    preload(32'h800, 5, 32'hA0);
    run_copy(32'h800, 32'h900, 16'd5, 32'hA0, 13);       // start pulse during FIN

    run_copy(32'h40, 32'h140, 16'd0, 32'h0, 0);
    run_copy(32'h2, 32'h200, 16'd3, 32'h0, 0);
    repeat (3) @(posedge clk);

    preload(32'hFFFF_FFF8, 4, 32'hC0DE_0000);
    run_copy(32'hFFFF_FFF8, 32'h300, 16'd4, 32'hC0DE_0000, 0);

    run_copy(32'h10, 32'h302, 16'd2, 32'h0, 0);

    // Reset during READ: only the first read may appear
    preload(32'h400, 8, 32'h5000_0000);
    e.rel = 1; e.we = 1'b0; e.addr = 32'h400; e.data = 32'h0; e.be = 4'h0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    prev_err   = new_err;
    new_err    = 1'b0;
    t0         = cyc;
    done_rel   = 19;
    start_i    = 1'b1;
    src_addr_i = 32'h400;
    dst_addr_i = 32'h480;
    len_i      = 16'd8;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    done_rel = 0;
    #1;
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'd0);
    chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    preload(32'h500, 1, 32'h1234_5678);
    run_copy(32'h500, 32'h600, 16'd1, 32'h1234_5678, 0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
